// File: rtl/piso.sv
// Parallel-in, serial-out shift register: load a WIDTH-bit word with sel=0,
// then shift it out LSB-first on v with sel=1, zero-filling from the top.
module piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [WIDTH-1:0] d,
    output logic             v
);

    logic [WIDTH-1:0] q;

    // Reset is tested first so an unknown sel/d cannot leak into q.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (!sel)
            q <= d;
        else
            q <= {1'b0, q[WIDTH-1:1]};
    end

    assign v = q[0];

endmodule

// File: tb/tb_piso.sv
// Directed vector bench for piso (WIDTH=4): table of per-edge inputs and
// expected serial output, plus hand sequences for shift-mode d noise.
module tb_piso;

    localparam int WIDTH = 4;
    localparam int MAXV  = 64;

    logic             clk;
    logic             reset;
    logic             sel;
    logic [WIDTH-1:0] d;
    logic             v;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             reset;
        logic             sel;
        logic [WIDTH-1:0] d;
        logic             exp_v;
        string            name;
    } vec_t;

    vec_t vecs[MAXV];
    int   nv = 0;

    piso #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .d     (d),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic [WIDTH-1:0] dd,
                       input logic e, input string nm);
        vecs[nv].reset = r;
        vecs[nv].sel   = s;
        vecs[nv].d     = dd;
        vecs[nv].exp_v = e;
        vecs[nv].name  = nm;
        nv++;
    endtask

    // Drive inputs away from the edge, take one edge, sample 1 time unit later.
    task automatic step(input logic r, input logic s, input logic [WIDTH-1:0] dd,
                        input logic e, input string nm);
        reset = r;
        sel   = s;
        d     = dd;
        @(posedge clk);
        #1;
        total++;
        if (v !== e) begin
            bad++;
            $display("FAIL %s: v=%b expected=%b", nm, v, e);
        end
    endtask

    initial begin
        reset = 1'b0;
        sel   = 1'b0;
        d     = '0;

        // Reset with unknown controls, then held while sel/d toggle.
        add(1'b1, 1'bx, 4'bxxxx, 1'b0, "rst_x");
        add(1'b1, 1'b0, 4'b1111, 1'b0, "rst_hold_load");
        add(1'b1, 1'b1, 4'b0101, 1'b0, "rst_hold_shift");
        add(1'b1, 1'b0, 4'b0001, 1'b0, "rst_hold_load1");

        // Load 0100 and shift 5: 0,1,0,0,0.
        add(1'b0, 1'b0, 4'b0100, 1'b0, "ld0100");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0100_1");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh0100_2");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0100_3");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0100_4");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0100_5");

        // Reload after drain: 1110 -> 1,1,1,0 then stays 0.
        add(1'b0, 1'b0, 4'b1110, 1'b0, "ld1110");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1110_1");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1110_2");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1110_3");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh1110_4");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh1110_5");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh1110_6");

        // Load overrides shift; q=0110 is observed by draining it.
        add(1'b0, 1'b0, 4'b1011, 1'b1, "ld1011");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1011_1");
        add(1'b0, 1'b0, 4'b0110, 1'b0, "ld0110_ovr");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh0110_1");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh0110_2");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0110_3");
        add(1'b0, 1'b1, 4'b0000, 1'b0, "sh0110_4");

        // Reset mid-shift with sel=1.
        add(1'b0, 1'b0, 4'b1111, 1'b1, "ld1111");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1111_1");
        add(1'b0, 1'b1, 4'b0000, 1'b1, "sh1111_2");
        add(1'b1, 1'b1, 4'b1111, 1'b0, "rst_mid");
        add(1'b0, 1'b1, 4'b1111, 1'b0, "post_rst_1");
        add(1'b0, 1'b1, 4'b1111, 1'b0, "post_rst_2");

        // Consecutive loads track d every edge.
        add(1'b0, 1'b0, 4'b0011, 1'b1, "cld_0011");
        add(1'b0, 1'b0, 4'b0010, 1'b0, "cld_0010");
        add(1'b0, 1'b0, 4'b0101, 1'b1, "cld_0101");
        add(1'b0, 1'b1, 4'b1111, 1'b0, "cld_sh_1");
        add(1'b0, 1'b1, 4'b1111, 1'b1, "cld_sh_2");
        add(1'b0, 1'b1, 4'b1111, 1'b0, "cld_sh_3");

        for (int i = 0; i < nv; i++)
            step(vecs[i].reset, vecs[i].sel, vecs[i].d, vecs[i].exp_v, vecs[i].name);

        // d ignored in shift mode: 0001 shifts out 0,0,0,0 whatever d does.
        step(1'b0, 1'b0, 4'b0001, 1'b1, "ign_ld0001");
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 4'($urandom), 1'b0, "ign_shift");

        // Noisy d during a fuller word: 1001 -> 0,0,1,0 after the load edge.
        step(1'b0, 1'b0, 4'b1001, 1'b1, "ign_ld1001");
        step(1'b0, 1'b1, 4'($urandom), 1'b0, "ign1001_1");
        step(1'b0, 1'b1, 4'($urandom), 1'b0, "ign1001_2");
        step(1'b0, 1'b1, 4'($urandom), 1'b1, "ign1001_3");
        step(1'b0, 1'b1, 4'($urandom), 1'b0, "ign1001_4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
